mem_stage_lat: RTL and testbench
================================

Name: mem_stage_lat

Overview:
Parametrised successor to the single-cycle memory stage. Performs RISC-V byte, halfword and word loads/stores against a byte-lane data RAM with configurable access latency. Loads are sign- or zero-extended, and misaligned accesses are detected and suppressed. The stage stalls the pipeline through StallM and drives the M/W pipeline register, with a bubble-insert flush. It sits between the execute-cycle outputs and the writeback cycle, and StallM feeds the hazard unit.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the data RAM (power of two).
MEM_LAT, 1, wait cycles per memory access (0..7); 0 gives single-cycle access.
ADDR_W, $clog2(DEPTH_WORDS), localparam: word-index width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
RegWriteM  in  1  register write enable of the M instruction
ResultSrcM  in  1  writeback mux select (1 = load data)
MemWriteM  in  1  store request
MemReadM  in  1  load request
Funct3M  in  3  access size/sign (RISC-V funct3)
ALUResultM  in  32  byte address, or ALU result passed through
WriteDataM  in  32  store data (right-aligned)
PCPlus4M  in  32  PC+4 passthrough
RdM  in  5  destination register
FlushW  in  1  insert a bubble into the W register
StallM  out  1  combinational; holds IF/ID/EX/M when 1
MisalignM  out  1  combinational misaligned-access flag
RegWriteW  out  1  registered
ResultSrcW  out  1  registered
ALUResultW  out  32  registered
PCPlus4W  out  32  registered
ReadDataW  out  32  registered, extended load data
RdW  out  5  registered

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Reset: all W outputs are 0; FSM goes to IDLE; cnt is 0. RAM contents are not cleared. Reset mid-access aborts the access, and no write occurs.
- Address decode:
  - Word index = ALUResultM[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Lane = ALUResultM[1:0].
- Funct3 codes:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - 011, 110 and 111 are treated as W.
  - Stores use the size only.
- Misalignment: MisalignM = access & ((H or HU) & addr[0] | W & addr[1:0]!=0), where access = MemReadM|MemWriteM. A misaligned access causes:
  - no RAM write,
  - no stall,
  - RegWriteW=0 and ReadDataW=0 for that instruction.
- Read/write priority: if MemWriteM and MemReadM are both 1, the store wins, the load is ignored, and ReadDataW=0.
- Stores:
  - SB writes lane addr[1:0] with WriteDataM[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with WriteDataM[15:0].
  - SW writes all four lanes.
- Loads: select the byte or half at the lane. B and H sign-extend; BU and HU zero-extend; W passes all 32 bits. Non-loads give ReadDataW=0.
- Latency FSM (valid = access & !MisalignM):
  - IDLE, valid, MEM_LAT>0: StallM=1, cnt<=1, go to BUSY.
  - BUSY, cnt<MEM_LAT: StallM=1, cnt++.
  - BUSY, cnt==MEM_LAT: StallM=0, access completes, go to IDLE, cnt<=0.
  - MEM_LAT=0: never stalls.
- Access timing: each valid access occupies M for MEM_LAT+1 cycles. The RAM write commits only in the completing (StallM=0) cycle, so it happens exactly once. Load data is sampled in that same cycle.
- Upstream holds all M inputs stable while StallM=1.
- W register update order:
  1. rst clears it.
  2. Else FlushW or StallM=1 loads a bubble (RegWriteW=0, ResultSrcW=0, RdW=0, data 0).
  3. Else it captures M.
- FlushW does not abort an access in progress in M.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU,
  - FSM state localparams S_IDLE and S_BUSY,
  - the bubble value.
- Sub-module dmem_bytelane: DEPTH_WORDS x 32 RAM with a 4-bit byte-enable write on the clk edge and an asynchronous word read.
- The top level contains the FSM, lane/extension logic and W register. Expected size is roughly 200 RTL lines.

Test Plan:
- MEM_LAT=0: SW 0xDEADBEEF @0x10, then LW @0x10 → ReadDataW=0xDEADBEEF one cycle after the load; StallM never 1.
- MEM_LAT=2: LW @0x10 → StallM=1 for 2 cycles, two W bubbles (RegWriteW=0), then data on the 3rd edge; the RAM is written exactly once for a store with the same timing.
- After SW 0x80FF7F01 @0x20:
  - LB @0x23 → 0xFFFFFF80; LBU @0x23 → 0x00000080.
  - LH @0x22 → 0xFFFF80FF; LHU → 0x000080FF.
  - SB 0xAA @0x21, then LW → 0x80FFAA01.
- Misaligned:
  - LW @0x22 → MisalignM=1, StallM=0, RegWriteW=0, ReadDataW=0.
  - SH @0x21 → memory word unchanged.
- Wrap: SW 0x12345678 @(DEPTH_WORDS*4+0x4) → LW @0x4 returns 0x12345678.
- Control events:
  - FlushW during a plain ALU op → W bubble.
  - rst asserted in BUSY with a pending SW → FSM IDLE, StallM=0, target word unchanged, W outputs 0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the latency-configurable memory stage.
// Holds funct3 codes, FSM states, access sizes and the M/W bundle.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef struct packed {
    logic        regWrite;
    logic        resultSrc;
    logic [31:0] aluResult;
    logic [31:0] pcPlus4;
    logic [31:0] readData;
    logic [4:0]  rd;
  } mw_t;

  localparam mw_t MW_BUBBLE = '0;

endpackage

// File: rtl/dmem_bytelane.sv
// Data RAM: DEPTH_WORDS x 32, byte-enable write on clk, async word read.
// Ports: clk, addr (word index), be, wdata (lane-aligned), rdata.
module dmem_bytelane #(
  parameter int DEPTH_WORDS = 1024,
  localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_lat.sv
// Memory stage with MEM_LAT wait cycles, byte/half/word access and M/W reg.
// Ports: M-side controls/data in, StallM/MisalignM out, registered W bundle.
module mem_stage_lat
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  input  logic        FlushW,
  output logic        StallM,
  output logic        MisalignM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT = 3'(MEM_LAT);

  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        lane;
  logic              unusedAddr;
  size_t             size;
  logic              access;
  logic              valid;
  logic              done;
  logic              isLoad;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [31:0]       loadData;
  state_t            state, stateNext;
  logic [2:0]        cnt, cntNext;
  mw_t               w;

  assign wordIdx    = ALUResultM[ADDR_W+1:2];
  assign lane       = ALUResultM[1:0];
  assign unusedAddr = ^ALUResultM[31:ADDR_W+2];

  always_comb begin
    size = SZ_W;
    unique case (Funct3M)
      F3_B, F3_BU: size = SZ_B;
      F3_H, F3_HU: size = SZ_H;
      default:     size = SZ_W;
    endcase
  end

  assign access    = MemReadM | MemWriteM;
  assign MisalignM = access &
    (((size == SZ_H) & lane[0]) |
     ((size == SZ_W) & (lane != 2'b00)));
  assign valid     = access & ~MisalignM;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    StallM    = 1'b0;
    if (LAT != 3'd0) begin
      unique case (state)
        S_IDLE: begin
          if (valid) begin
            StallM    = 1'b1;
            cntNext   = 3'd1;
            stateNext = S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt < LAT) begin
            StallM  = 1'b1;
            cntNext = cnt + 3'd1;
          end else begin
            cntNext   = 3'd0;
            stateNext = S_IDLE;
          end
        end
        default: begin
          cntNext   = 3'd0;
          stateNext = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Commit only in the completing cycle; reset in that cycle aborts it.
  assign done = valid & ~StallM;

  always_comb begin
    be    = 4'b0000;
    wdata = WriteDataM;
    unique case (size)
      SZ_B: wdata = {4{WriteDataM[7:0]}};
      SZ_H: wdata = {2{WriteDataM[15:0]}};
      default: wdata = WriteDataM;
    endcase
    if (done & MemWriteM & ~rst) begin
      unique case (size)
        SZ_B: be = 4'b0001 << lane;
        SZ_H: be = lane[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
  end

  dmem_bytelane #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .addr (wordIdx),
    .be   (be),
    .wdata(wdata),
    .rdata(rdata)
  );

  // A simultaneous store wins, so the load side returns zero.
  assign isLoad  = MemReadM & ~MemWriteM & ~MisalignM;
  assign byteSel = rdata[{lane, 3'b000} +: 8];
  assign halfSel = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    loadData = 32'd0;
    if (isLoad) begin
      unique case (size)
        SZ_B: loadData = Funct3M[2] ? {24'd0, byteSel}
                                    : {{24{byteSel[7]}}, byteSel};
        SZ_H: loadData = Funct3M[2] ? {16'd0, halfSel}
                                    : {{16{halfSel[15]}}, halfSel};
        default: loadData = rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w <= MW_BUBBLE;
    end else if (FlushW | StallM) begin
      w <= MW_BUBBLE;
    end else begin
      w.regWrite  <= RegWriteM & ~MisalignM;
      w.resultSrc <= ResultSrcM;
      w.aluResult <= ALUResultM;
      w.pcPlus4   <= PCPlus4M;
      w.readData  <= loadData;
      w.rd        <= RdM;
    end
  end

  assign RegWriteW  = w.regWrite;
  assign ResultSrcW = w.resultSrc;
  assign ALUResultW = w.aluResult;
  assign PCPlus4W   = w.pcPlus4;
  assign ReadDataW  = w.readData;
  assign RdW        = w.rd;

endmodule

// File: tb/tb_mem_stage_lat.sv
// Bench for mem_stage_lat: MEM_LAT=2 instance under a W-bundle scoreboard,
// plus a MEM_LAT=0 instance for the single-cycle path.
module tb_mem_stage_lat;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        RegWriteM, ResultSrcM, MemWriteM, MemReadM, FlushW;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM, MisalignM, RegWriteW, ResultSrcW;
  logic [31:0] ALUResultW, PCPlus4W, ReadDataW;
  logic [4:0]  RdW;

  logic        zRegWriteM, zResultSrcM, zMemWriteM, zMemReadM;
  logic [2:0]  zFunct3M;
  logic [31:0] zALUResultM, zWriteDataM;
  logic [4:0]  zRdM;
  logic        zStallM, zMisalignM, zRegWriteW, zResultSrcW;
  logic [31:0] zALUResultW, zPCPlus4W, zReadDataW;
  logic [4:0]  zRdW;

  mem_stage_lat #(.DEPTH_WORDS(1024), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .FlushW(FlushW),
    .StallM(StallM), .MisalignM(MisalignM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W),
    .ReadDataW(ReadDataW), .RdW(RdW)
  );

  mem_stage_lat #(.DEPTH_WORDS(1024), .MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .RegWriteM(zRegWriteM), .ResultSrcM(zResultSrcM),
    .MemWriteM(zMemWriteM), .MemReadM(zMemReadM),
    .Funct3M(zFunct3M), .ALUResultM(zALUResultM),
    .WriteDataM(zWriteDataM), .PCPlus4M(32'd0),
    .RdM(zRdM), .FlushW(1'b0),
    .StallM(zStallM), .MisalignM(zMisalignM),
    .RegWriteW(zRegWriteW), .ResultSrcW(zResultSrcW),
    .ALUResultW(zALUResultW), .PCPlus4W(zPCPlus4W),
    .ReadDataW(zReadDataW), .RdW(zRdW)
  );

  int errors = 0;
  int checks = 0;
  int pcCnt = 0;
  logic live = 1'b0;
  logic capS = 1'b0;
  logic [102:0] expQ[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Sample capture conditions before the edge, compare after it.
  always @(negedge clk) capS = live & ~StallM & ~FlushW & ~rst;

  always @(posedge clk) begin
    logic [102:0] got, exp;
    #1;
    got = {RegWriteW, ResultSrcW, ALUResultW, PCPlus4W, ReadDataW, RdW};
    exp = '0;
    if (capS) begin
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL wreg: unexpected capture %h", got);
      end else begin
        exp = expQ.pop_front();
      end
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wreg: got %h expected %h", got, exp);
    end
  end

  task automatic idle();
    RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; MemReadM = 0;
    Funct3M = 0; ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0;
    RdM = 0; FlushW = 0; live = 0;
  endtask

  task automatic op(
    input logic rw, rs, mw, mr,
    input logic [2:0] f3,
    input logic [31:0] a, wd,
    input logic [4:0] rd,
    input logic [31:0] expData,
    input logic expMis, flush
  );
    int n, stalls, expStalls;
    @(posedge clk); #2;
    pcCnt++;
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; MemReadM = mr;
    Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    PCPlus4M = pcCnt * 4; RdM = rd; FlushW = flush; live = 1;
    if (!flush)
      expQ.push_back({rw & ~expMis, rs, a, PCPlus4M, expData, rd});
    expStalls = ((mw | mr) & ~expMis) ? 2 : 0;
    n = 0; stalls = 0;
    forever begin
      @(negedge clk);
      if (n == 0) check("misalign", {31'd0, MisalignM}, {31'd0, expMis});
      if (!StallM) break;
      stalls++; n++;
      if (n > 20) begin
        errors++;
        $display("FAIL stall timeout: got %0d stalls expected %0d", stalls, expStalls);
        break;
      end
    end
    check("stallcycles", stalls, expStalls);
    @(posedge clk); #2;
    idle();
  endtask

  initial begin
    idle();
    zRegWriteM = 0; zResultSrcM = 0; zMemWriteM = 0; zMemReadM = 0;
    zFunct3M = 0; zALUResultM = 0; zWriteDataM = 0; zRdM = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;

    // Single-cycle instance
    @(posedge clk); #2;
    zMemWriteM = 1; zFunct3M = 3'b010; zALUResultM = 32'h10;
    zWriteDataM = 32'hDEADBEEF;
    @(negedge clk) check("lat0 sw stall", {31'd0, zStallM}, 32'd0);
    @(posedge clk); #2;
    zMemWriteM = 0; zMemReadM = 1; zRegWriteM = 1; zResultSrcM = 1; zRdM = 5'd3;
    @(negedge clk) check("lat0 lw stall", {31'd0, zStallM}, 32'd0);
    @(posedge clk); #1;
    check("lat0 lw data", zReadDataW, 32'hDEADBEEF);
    check("lat0 lw rw", {31'd0, zRegWriteW}, 32'd1);
    #1 zMemReadM = 0; zRegWriteM = 0; zResultSrcM = 0; zRdM = 0;

    // MEM_LAT=2 instance
    //  rw rs mw mr f3    addr     wdata         rd  expData       mis flush
    op(0, 0, 1, 0, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0, 0);
    op(1, 1, 0, 1, 3'd2, 32'h10, 32'h0,        1, 32'hDEADBEEF, 0, 0);
    op(0, 0, 1, 0, 3'd2, 32'h20, 32'h80FF7F01, 0, 32'h0,        0, 0);
    op(1, 1, 0, 1, 3'd0, 32'h23, 32'h0,        2, 32'hFFFFFF80, 0, 0);
    op(1, 1, 0, 1, 3'd4, 32'h23, 32'h0,        3, 32'h00000080, 0, 0);
    op(1, 1, 0, 1, 3'd1, 32'h22, 32'h0,        4, 32'hFFFF80FF, 0, 0);
    op(1, 1, 0, 1, 3'd5, 32'h22, 32'h0,        5, 32'h000080FF, 0, 0);
    op(0, 0, 1, 0, 3'd0, 32'h21, 32'h000000AA, 0, 32'h0,        0, 0);
    op(1, 1, 0, 1, 3'd2, 32'h20, 32'h0,        6, 32'h80FFAA01, 0, 0);
    op(1, 1, 0, 1, 3'd1, 32'h20, 32'h0,        7, 32'hFFFFAA01, 0, 0);
    op(1, 1, 0, 1, 3'd2, 32'h22, 32'h0,        8, 32'h0,        1, 0);
    op(0, 0, 1, 0, 3'd1, 32'h21, 32'h00005555, 0, 32'h0,        1, 0);
    op(1, 1, 0, 1, 3'd2, 32'h20, 32'h0,        9, 32'h80FFAA01, 0, 0);
    op(0, 0, 1, 0, 3'd2, 32'h1004, 32'h12345678, 0, 32'h0,      0, 0);
    op(1, 1, 0, 1, 3'd2, 32'h4,  32'h0,       10, 32'h12345678, 0, 0);
    op(1, 1, 1, 1, 3'd2, 32'h30, 32'hA5A5A5A5,11, 32'h0,        0, 0);
    op(1, 1, 0, 1, 3'd2, 32'h30, 32'h0,       12, 32'hA5A5A5A5, 0, 0);
    op(1, 0, 0, 0, 3'd0, 32'h1234, 32'h0,     13, 32'h0,        0, 1);
    op(1, 0, 0, 0, 3'd0, 32'h5678, 32'h0,     14, 32'h0,        0, 0);

    // Reset in the completing cycle of a store aborts it
    @(posedge clk); #2;
    MemWriteM = 1; Funct3M = 3'd2; ALUResultM = 32'h30;
    WriteDataM = 32'hCAFEBABE;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #2;
    idle();
    @(negedge clk) check("rst stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #2 rst = 0;
    op(1, 1, 0, 1, 3'd2, 32'h30, 32'h0,       15, 32'hA5A5A5A5, 0, 0);

    repeat (3) @(posedge clk);
    #2 check("queue empty", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
